p2s_uart_tx: RTL
================

// Module: p2s_uart_tx
// PURPOSE
//  Parallel-to-serial stage between the message senders and the Arduino link.
//  - Accepts one byte per LoadByte strobe from a header/data message sender.
//  - Shifts the byte out LSB-first as an 8N1 UART frame on TxD.
//  - Double-buffered (holding reg + shift reg), so the sender can stage the next byte mid-frame.
//  - P2S_Empty paces the upstream sender.
// PARAMETERS
//  ClocksPerBit  5208  Clock cycles per serial bit (50 MHz / 9600 baud); must be >= 2
// PORTS
//  Clock      in   1  system clock, all logic on rising edge
//  Clear      in   1  synchronous, active-high reset
//  LoadByte   in   1  strobe: capture MsgByte into holding register
//  MsgByte    in   8  byte to transmit
//  P2S_Empty  out  1  holding register free; LoadByte accepted only while high
//  Busy       out  1  frame in progress on TxD
//  TxD        out  1  serial output, idle high
// BEHAVIOUR
//  Reset (Clear=1 at an edge): TxD=1, P2S_Empty=1, Busy=0, state IDLE, bit counter=0, holding reg invalid.
//  Clear mid-frame: frame aborted; TxD=1 from the next cycle; holding byte discarded.
//  Load: LoadByte=1 and P2S_Empty=1 at edge k.
//    - Holding reg <= MsgByte; P2S_Empty=0 after edge k.
//    - LoadByte while P2S_Empty=0 is ignored; the current holding byte is retained.
//  Transfer: in IDLE with holding valid (edge k+1):
//    - shift reg <= holding; holding invalid; state START.
//    - TxD=0 and Busy=1 after edge k+1; P2S_Empty=1 after edge k+1.
//  State machine, every bit held exactly ClocksPerBit cycles:
//    IDLE -> START (TxD=0) -> DATA (8 bits, LSB first) -> [PARITY] -> STOP (TxD=1) -> IDLE/START
//  End of STOP:
//    - Holding valid: transfer, go directly to START. Back-to-back frames, no idle gap.
//    - Holding empty: go to IDLE; Busy=0, TxD=1.
//  Simultaneous LoadByte and transfer in the same cycle: P2S_Empty is still 0, so the load is ignored.
//  Bit-time counter: width $clog2(ClocksPerBit), counts 0..ClocksPerBit-1, wraps to 0 at each bit boundary.
//  Data bit index: 3 bits, 0..7, no wrap beyond 7.
//  Frame length: 10*ClocksPerBit cycles (11*ClocksPerBit with parity).
// CONFIGURATION
//  Macro P2S_PARITY_EN.
//  - Defined: PARITY state inserted after bit 7. The parity bit is even parity (XOR of the 8 data bits),
//    held for ClocksPerBit cycles. Frame is 8E1.
//  - Undefined: no PARITY state; frame is 8N1.
// STRUCTURE
//  Shared package p2s_pkg:
//  - state enum {IDLE, START, DATA, PARITY, STOP}
//  - constant DATA_BITS=8
//  - functions for counter width and frame length
//  Sub-module bit_timer: counter that emits a one-cycle BitDone at count ClocksPerBit-1 and restarts on Restart.
//  Top level holds the FSM, holding and shift registers, and TxD mux.
// TESTING (ClocksPerBit=4)
//  1. Reset: assert Clear 3 cycles -> TxD=1, P2S_Empty=1, Busy=0; no TxD transitions while idle.
//  2. Load 0xA5 -> start 2 cycles after strobe; TxD = 0,1,0,1,0,0,1,0,1,1, 4 cycles each; Busy low after 40 cycles.
//  3. Load 0x3C, then 0xC3 when P2S_Empty rises -> two frames contiguous; stop bit of frame 1 followed
//     immediately by start bit of frame 2; 80 cycles total.
//  4. Load 0x11, 0x22, then 0x33 while P2S_Empty=0 -> only 0x11 and 0x22 are transmitted.
//  5. Clear at cycle 15 of a 0x00 frame -> TxD=1 next cycle, P2S_Empty=1, Busy=0; a following 0x55
//     load sends a clean frame.
//  6. P2S_PARITY_EN defined: 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame length 44 cycles.

Source files
------------

// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared types, constants and sizing helpers for the p2s UART transmitter
package p2s_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } p2s_state_e;

    localparam int DATA_BITS = 8;

    // Width of the bit-time counter; ClocksPerBit is at least 2, so this is at least 1.
    function automatic int cnt_width(input int clocks_per_bit);
        return $clog2(clocks_per_bit);
    endfunction

    // Whole-frame duration in clock cycles: start + data + optional parity + stop.
    function automatic int frame_len(input int clocks_per_bit, input bit parity_en);
        return (DATA_BITS + 2 + (parity_en ? 1 : 0)) * clocks_per_bit;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit-time counter that pulses BitDone on the last cycle of each serial bit
module bit_timer
    import p2s_pkg::*;
#(
    parameter int ClocksPerBit = 5208
) (
    input  logic Clock,
    input  logic Clear,
    input  logic Restart,
    output logic BitDone
);

    localparam int CW = cnt_width(ClocksPerBit);
    localparam logic [CW-1:0] LAST = CW'(ClocksPerBit - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: hold at zero while restarting, otherwise count up and wrap at a bit boundary.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (Restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A restart means a fresh bit is beginning, so the old count cannot end it.
    assign BitDone = (cnt_q == LAST) && !Restart;

endmodule

// File: rtl/p2s_uart_tx.sv
// rtl/p2s_uart_tx.sv - double-buffered parallel-to-serial UART transmitter (8N1, or 8E1 with P2S_PARITY_EN)
module p2s_uart_tx
    import p2s_pkg::*;
#(
    parameter int ClocksPerBit = 5208
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       LoadByte,
    input  logic [7:0] MsgByte,
    output logic       P2S_Empty,
    output logic       Busy,
    output logic       TxD
);

    p2s_state_e state_q;
    logic [7:0] hold_q;
    logic       hold_valid_q;
    logic [7:0] shift_q;
    logic [2:0] bit_idx_q;
    logic       txd_q;
    logic       busy_q;
`ifdef P2S_PARITY_EN
    logic       parity_q;
`endif

    logic bit_done;
    logic start_frame;

    // The timer is parked at zero while idle so the start bit always gets a full bit time.
    bit_timer #(
        .ClocksPerBit(ClocksPerBit)
    ) u_bit_timer (
        .Clock  (Clock),
        .Clear  (Clear),
        .Restart(state_q == IDLE),
        .BitDone(bit_done)
    );

    // A staged byte moves into the shifter from idle, or straight after a stop bit for gapless frames.
    assign start_frame = hold_valid_q &&
                         ((state_q == IDLE) || ((state_q == STOP) && bit_done));

    // Frame FSM together with holding/shift registers and the registered serial output.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
`ifdef P2S_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            // Loads are only taken while the holding register is free.
            if (LoadByte && !hold_valid_q) begin
                hold_q       <= MsgByte;
                hold_valid_q <= 1'b1;
            end

            if (start_frame) begin
                shift_q      <= hold_q;
                hold_valid_q <= 1'b0;
                state_q      <= START;
                txd_q        <= 1'b0;
                busy_q       <= 1'b1;
`ifdef P2S_PARITY_EN
                parity_q     <= ^hold_q;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    START: begin
                        if (bit_done) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                            txd_q     <= shift_q[0];
                        end
                    end
                    DATA: begin
                        if (bit_done) begin
                            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef P2S_PARITY_EN
                                state_q <= PARITY;
                                txd_q   <= parity_q;
`else
                                state_q <= STOP;
                                txd_q   <= 1'b1;
`endif
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                                shift_q   <= shift_q >> 1;
                                txd_q     <= shift_q[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_done) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_done) begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign P2S_Empty = !hold_valid_q;
    assign Busy      = busy_q;
    assign TxD       = txd_q;

endmodule
